// File: rtl/plab5_mcore_net_msg_to_mem_req_msg.sv
// Network-to-memory request adapter for one bank: queues inbound network
// messages, restamps the memory opaque field with the source id, and limits
// how many requests each source may have in flight at the bank.
module plab5_mcore_net_msg_to_mem_req_msg #(
  parameter int unsigned p_bank_id           = 0,
  parameter int unsigned p_num_ports         = 4,
  parameter int unsigned p_mem_opaque_nbits  = 8,
  parameter int unsigned p_mem_addr_nbits    = 32,
  parameter int unsigned p_mem_data_nbits    = 32,
  parameter int unsigned p_net_opaque_nbits  = 4,
  parameter int unsigned p_net_srcdest_nbits = 3,
  parameter int unsigned p_max_outstanding   = 4,
  localparam int unsigned c_type_nbits = 3,
  localparam int unsigned c_len_nbits  = $clog2(p_mem_data_nbits / 8),
  localparam int unsigned c_req_nbits  = c_type_nbits + p_mem_opaque_nbits
                                       + p_mem_addr_nbits + c_len_nbits
                                       + p_mem_data_nbits,
  localparam int unsigned c_net_nbits  = 2 * p_net_srcdest_nbits
                                       + p_net_opaque_nbits + c_req_nbits
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sd,
  input  logic                           net_val,
  output logic                           net_rdy,
  input  logic [c_net_nbits-1:0]         net_msg,
  output logic                           mem_req_val,
  input  logic                           mem_req_rdy,
  output logic [c_req_nbits-1:0]         mem_req_msg,
  input  logic                           resp_done,
  input  logic [p_net_srcdest_nbits-1:0] resp_src,
  output logic                           err,
  output logic [5:0]                     outstanding_total
);

  localparam int unsigned c_sd_nbits  = p_net_srcdest_nbits;
  // opaque sits just above addr/len/data; its top bits carry the source id
  localparam int unsigned c_opq_lsb   = p_mem_data_nbits + c_len_nbits + p_mem_addr_nbits;
  localparam int unsigned c_opq_msb   = c_opq_lsb + p_mem_opaque_nbits - 1;
  localparam int unsigned c_nopq_lsb  = c_req_nbits;
  localparam int unsigned c_nopq_msb  = c_req_nbits + p_net_opaque_nbits - 1;

  logic [c_sd_nbits-1:0]  net_dest;
  logic [c_sd_nbits-1:0]  net_src;
  logic [c_req_nbits-1:0] net_payload;

  logic [c_sd_nbits-1:0]  fifo_src [2];
  logic [c_req_nbits-1:0] fifo_pay [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;

  logic [2:0]             cnt      [p_num_ports];
  logic [2:0]             cnt_next [p_num_ports];
  logic [2:0]             head_cnt;
  logic [c_sd_nbits-1:0]  head_src;

  logic net_fire;
  logic dest_ok;
  logic enq;
  logic deq;
  logic stall;
  logic resp_ok;
  logic err_set;

  // security label and network opaque have no functional effect here
  logic unused_bits;
  assign unused_bits = ^{sd, net_msg[c_nopq_msb:c_nopq_lsb]};

  // network header decode
  assign net_dest    = net_msg[c_net_nbits-1 -: c_sd_nbits];
  assign net_src     = net_msg[c_net_nbits-1-c_sd_nbits -: c_sd_nbits];
  assign net_payload = net_msg[c_req_nbits-1:0];

  // handshake and queue control
  assign net_rdy     = (count != 2'd2);
  assign net_fire    = net_val && net_rdy;
  assign dest_ok     = (net_dest == c_sd_nbits'(p_bank_id));
  assign enq         = net_fire && dest_ok;
  assign head_src    = fifo_src[rd_ptr];
  assign stall       = (head_cnt == 3'(p_max_outstanding));
  assign mem_req_val = (count != 2'd0) && !stall;
  assign deq         = mem_req_val && mem_req_rdy;
  assign resp_ok     = (32'(resp_src) < p_num_ports);

  // head counter lookup; out-of-range sources never stall
  always_comb begin
    head_cnt = 3'd0;
    for (int unsigned i = 0; i < p_num_ports; i++) begin
      if (head_src == c_sd_nbits'(i)) head_cnt = cnt[i];
    end
  end

  // outbound message: head payload with opaque top bits restamped by source
  always_comb begin
    mem_req_msg = fifo_pay[rd_ptr];
    mem_req_msg[c_opq_msb -: c_sd_nbits] = head_src;
  end

  // per-source counter next state and error detection
  always_comb begin
    err_set = net_fire && !dest_ok;
    if (resp_done && !resp_ok) err_set = 1'b1;
    for (int unsigned i = 0; i < p_num_ports; i++) begin
      cnt_next[i] = cnt[i];
      if (deq && (head_src == c_sd_nbits'(i)) &&
          !(resp_done && (resp_src == c_sd_nbits'(i)))) begin
        cnt_next[i] = cnt[i] + 3'd1;
      end else if (resp_done && (resp_src == c_sd_nbits'(i)) &&
                   !(deq && (head_src == c_sd_nbits'(i)))) begin
        if (cnt[i] == 3'd0) err_set = 1'b1;
        else                cnt_next[i] = cnt[i] - 3'd1;
      end
    end
  end

  // total in-flight requests across all sources
  always_comb begin
    outstanding_total = 6'd0;
    for (int unsigned i = 0; i < p_num_ports; i++) begin
      outstanding_total = outstanding_total + 6'(cnt[i]);
    end
  end

  // queue pointers, occupancy, counters and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      err    <= 1'b0;
      for (int unsigned i = 0; i < p_num_ports; i++) cnt[i] <= 3'd0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (err_set) err <= 1'b1;
      for (int unsigned i = 0; i < p_num_ports; i++) cnt[i] <= cnt_next[i];
    end
  end

  // queue storage; validity is tracked by count, so no reset needed
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_src[wr_ptr] <= net_src;
      fifo_pay[wr_ptr] <= net_payload;
    end
  end

endmodule

// File: doc/plab5_mcore_net_msg_to_mem_req_msg.md
PLAB5_MCORE_NET_MSG_TO_MEM_REQ_MSG -- requirements
Module: plab5_mcore_NetMsgToMemReqMsg

Interface
REQ-001 SHALL have parameter p_bank_id, default 0: network destination index of this bank.
REQ-002 SHALL have parameter p_num_ports, default 4: number of network sources.
REQ-003 SHALL have parameters p_mem_opaque_nbits 8, p_mem_addr_nbits 32, p_mem_data_nbits 32: memory request message field widths.
REQ-004 SHALL have parameters p_net_opaque_nbits 4, p_net_srcdest_nbits 3: network header widths; payload width equals the memory request message width.
REQ-005 SHALL have parameter p_max_outstanding, default 4: per-source outstanding-request limit, 1..7.
REQ-006 SHALL have ports: clk in 1 clock; reset in 1, asynchronous active-high.
REQ-007 SHALL have ports: sd in 1 security domain select (label L); all message ports carry label Domain sd.
REQ-008 SHALL have ports: net_val in 1, net_rdy out 1, net_msg in net-msg width: inbound network message.
REQ-009 SHALL have ports: mem_req_val out 1, mem_req_rdy in 1, mem_req_msg out mem-req width: outbound memory request to bank.
REQ-010 SHALL have ports: resp_done in 1, resp_src in p_net_srcdest_nbits: one response for source resp_src left the bank this cycle.
REQ-011 SHALL have ports: err out 1 sticky error; outstanding_total out 6 sum of all per-source counters.

Function
REQ-012 SHALL hold a 2-entry FIFO of {src, payload}; net_rdy = !full; no enqueue/dequeue bypass, so minimum latency net fire -> mem_req_val is 1 cycle.
REQ-013 SHALL, on net_val && net_rdy with header dest == p_bank_id, enqueue {net src field, net payload}.
REQ-014 SHALL, on net fire with dest != p_bank_id, accept and discard the message (no enqueue) and set err.
REQ-015 SHALL drive mem_req_msg from FIFO head: payload unchanged except opaque top p_net_srcdest_nbits bits replaced by stored src; low opaque bits, type, addr, len, data unchanged.
REQ-016 SHALL keep one 3-bit counter per source; stall = (counter[head src] == p_max_outstanding).
REQ-017 SHALL drive mem_req_val = !empty && !stall; dequeue exactly when mem_req_val && mem_req_rdy.
REQ-018 SHALL increment counter[head src] on dequeue; decrement counter[resp_src] on resp_done; both to same source same cycle -> counter unchanged.
REQ-019 SHALL, on resp_done for a counter at 0, leave it at 0 and set err; resp_src >= p_num_ports SHALL set err and change no counter.
REQ-020 SHALL allow simultaneous enqueue and dequeue when FIFO holds 1 entry (count stays 1); when full, net_rdy is 0 that cycle regardless of dequeue.
REQ-021 SHALL keep FIFO pointers 1-bit wrap-around with separate count 0..2; head order is strictly arrival order (no reordering past a stalled head).
REQ-022 SHALL update outstanding_total combinationally as the sum of counters.

Reset
REQ-023 SHALL, while reset is high, asynchronously clear FIFO (empty), all counters, err; thus net_rdy=1, mem_req_val=0, err=0, outstanding_total=0.
REQ-024 SHALL discard any in-flight FIFO contents on reset mid-operation; no mem_req fire in the reset-deassertion cycle unless a new message was enqueued earlier.
REQ-025 SHALL hold err until reset; nothing else clears it.

Verification
REQ-026 Reset mid-stream: 2 entries queued, assert reset async between edges -> net_rdy=1, mem_req_val=0, outstanding_total=0 immediately.
REQ-027 Pass-through: p_bank_id=1, msg dest=1 src=2 opaque=0x05 addr=0x40 -> next cycle mem_req_val=1, opaque=0x45, addr=0x40, data unchanged.
REQ-028 Backpressure: mem_req_rdy=0, send 3 messages -> third sees net_rdy=0 after two accepted; release rdy -> order preserved, 1/cycle.
REQ-029 Outstanding limit: p_max_outstanding=2, src 0 sends 3 requests, no resp_done -> third held (mem_req_val=0, outstanding_total=2); resp_done src 0 -> third issues next cycle.
REQ-030 Errors: dest=3 with p_bank_id=0 -> message dropped, err=1; separately resp_done src 1 with counter 0 -> err=1, counter stays 0.
REQ-031 Same-cycle inc/dec on src 0 at counter 1 -> counter stays 1, outstanding_total unchanged.
